// File: rtl/psg_pkg.sv
// Shared types and constants for the PSG mix scheduler: widths, FSM states and the
// log-volume table used by the single shared converter.
package psg_pkg;

   localparam int unsigned MIX_W = 12;
   localparam int unsigned LVL_W = 5;
   localparam int unsigned LOG_W = 8;
   localparam int unsigned NUM_VOICES = 3;

   localparam logic [LOG_W-1:0] LOG_LUT [32] = '{
      8'd0,   8'd1,   8'd2,   8'd3,   8'd3,   8'd4,   8'd5,   8'd6,
      8'd8,   8'd9,   8'd11,  8'd13,  8'd16,  8'd18,  8'd24,  8'd29,
      8'd32,  8'd34,  8'd44,  8'd55,  8'd61,  8'd66,  8'd82,  8'd98,
      8'd114, 8'd130, 8'd148, 8'd166, 8'd187, 8'd207, 8'd231, 8'd255
   };

   typedef enum logic [2:0] {
      StIdle,
      StV0,
      StV1,
      StV2,
      StDone
   } state_e;

   // 5*L as a shift-and-add, 11 bits wide so 5*255 fits
   function automatic logic [10:0] weight5(input logic [LOG_W-1:0] l);
      return ({3'b000, l} << 2) + {3'b000, l};
   endfunction

endpackage

// File: rtl/psg_mix_sched_if.sv
// Sample-request / mixed-sample bundle between the PSG voice stage and the mixer.
interface psg_mix_sched_if;
   import psg_pkg::*;

   logic                  sample_stb;
   logic [LVL_W-1:0]      voice0;
   logic [LVL_W-1:0]      voice1;
   logic [LVL_W-1:0]      voice2;
   logic [NUM_VOICES-1:0] voice_mask;
   logic [MIX_W-1:0]      audio_out;
   logic                  out_valid;
   logic                  busy;
   logic                  overrun;

   modport master (
      output sample_stb, voice0, voice1, voice2, voice_mask,
      input  audio_out, out_valid, busy, overrun
   );

   modport slave (
      input  sample_stb, voice0, voice1, voice2, voice_mask,
      output audio_out, out_valid, busy, overrun
   );

endinterface

// File: rtl/psg_log_lut.sv
// Combinational linear-to-log volume converter, shared across all three voices.
module psg_log_lut
   import psg_pkg::*;
(
   input  logic [LVL_W-1:0] lvl,
   output logic [LOG_W-1:0] log_lvl
);

   assign log_lvl = LOG_LUT[lvl];

endmodule

// File: rtl/psg_mix_sched.sv
// Time-multiplexed PSG mixer: snapshots three voice levels per strobe and accumulates
// their weighted log volumes through one shared lookup, one voice per cycle.
module psg_mix_sched
   import psg_pkg::*;
(
   input logic            clk,
   input logic            reset,
   psg_mix_sched_if.slave bus
);

   state_e                state_q, state_d;
   logic [LVL_W-1:0]      snap_q [NUM_VOICES];
   logic [NUM_VOICES-1:0] mask_q;
   logic                  pending_q, pending_d;
   logic [MIX_W-1:0]      acc_q, acc_d;
   logic [MIX_W-1:0]      audio_q, audio_d;
   logic                  valid_q, valid_d;
   logic                  overrun_q, overrun_d;
   logic                  take_snap;

   logic [LVL_W-1:0]      sel_lvl;
   logic                  sel_mask;
   logic [LOG_W-1:0]      log_lvl;
   logic [10:0]           weighted;

   // Voice select for the shared lookup, driven only by registered state
   always_comb begin
      sel_lvl  = snap_q[0];
      sel_mask = mask_q[0];
      case (state_q)
         StV1: begin
            sel_lvl  = snap_q[1];
            sel_mask = mask_q[1];
         end
         StV2: begin
            sel_lvl  = snap_q[2];
            sel_mask = mask_q[2];
         end
         default: ;
      endcase
   end

   psg_log_lut u_log_lut (
      .lvl     (sel_lvl),
      .log_lvl (log_lvl)
   );

   assign weighted = sel_mask ? 11'd0 : weight5(log_lvl);

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      acc_d     = acc_q;
      audio_d   = audio_q;
      valid_d   = 1'b0;
      overrun_d = 1'b0;
      take_snap = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.sample_stb) begin
               take_snap = 1'b1;
               acc_d     = '0;
               state_d   = StV0;
            end
         end
         StV0, StV1, StV2: begin
            acc_d = acc_q + {1'b0, weighted};
            unique case (state_q)
               StV0:    state_d = StV1;
               StV1:    state_d = StV2;
               default: state_d = StDone;
            endcase
            // One request may queue behind the running sample; any further one is lost
            if (bus.sample_stb) begin
               if (pending_q) overrun_d = 1'b1;
               else           pending_d = 1'b1;
            end
         end
         StDone: begin
            audio_d = acc_q;
            valid_d = 1'b1;
            if (pending_q || bus.sample_stb) begin
               take_snap = 1'b1;
               acc_d     = '0;
               pending_d = 1'b0;
               state_d   = StV0;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         pending_q <= 1'b0;
         acc_q     <= '0;
         audio_q   <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         acc_q     <= acc_d;
         audio_q   <= audio_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_VOICES; i++) snap_q[i] <= '0;
         mask_q <= '0;
      end else if (take_snap) begin
         snap_q[0] <= bus.voice0;
         snap_q[1] <= bus.voice1;
         snap_q[2] <= bus.voice2;
         mask_q    <= bus.voice_mask;
      end
   end

   assign bus.audio_out = audio_q;
   assign bus.out_valid = valid_q;
   assign bus.overrun   = overrun_q;
   assign bus.busy      = (state_q != StIdle);

endmodule
